// File: rtl/disp_pkg.sv
// Shared definitions for the disparity window feeder: default geometry,
// derived widths, FSM state encoding and the window-array bit-offset helper.
package disp_pkg;

  localparam int unsigned WIN_DEF       = 15;
  localparam int unsigned DATA_SIZE_DEF = 8;
  localparam int unsigned IMG_W_DEF     = 64;
  localparam int unsigned MAX_DISP_DEF  = 64;

  localparam int unsigned DISP_BITS = $clog2(MAX_DISP_DEF);
  localparam int unsigned COL_BITS  = $clog2(IMG_W_DEF);
  localparam int unsigned ROW_BITS  = $clog2(WIN_DEF + 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CLR   = 2'd3
  } state_t;

  // Bit offset of pixel (r, c); row 0 is the oldest row.
  function automatic int unsigned pix_offset(input int unsigned r, input int unsigned c,
                                             input int unsigned img_w,
                                             input int unsigned data_size);
    return (r * img_w + c) * data_size;
  endfunction

endpackage

// File: rtl/disp_window_feeder_if.sv
// Pixel-stream, core-handshake and result signals of disp_window_feeder.
// timeout_err exists only when DISP_FEEDER_TIMEOUT_EN is defined.
interface disp_window_feeder_if
  import disp_pkg::*;
#(
  parameter int unsigned WIN       = WIN_DEF,
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned IMG_W     = IMG_W_DEF,
  parameter int unsigned MAX_DISP  = MAX_DISP_DEF
);
  localparam int unsigned DISP_W = $clog2(MAX_DISP);
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ARR_W  = DATA_SIZE * IMG_W * WIN;

  logic                 pix_valid;
  logic                 pix_ready;
  logic                 pix_sof;
  logic [DATA_SIZE-1:0] pix_L;
  logic [DATA_SIZE-1:0] pix_R;
  logic [ARR_W-1:0]     input_array_L;
  logic [ARR_W-1:0]     input_array_R;
  logic [COL_W-1:0]     col_index;
  logic                 input_ready;
  logic                 core_rst;
  logic                 done;
  logic [DISP_W-1:0]    output_disp;
  logic                 disp_valid;
  logic [DISP_W-1:0]    disp_out;
  logic [COL_W-1:0]     disp_col;
`ifdef DISP_FEEDER_TIMEOUT_EN
  logic                 timeout_err;
`endif

  modport master (
    input  pix_valid, pix_sof, pix_L, pix_R, done, output_disp,
`ifdef DISP_FEEDER_TIMEOUT_EN
    output timeout_err,
`endif
    output pix_ready, input_array_L, input_array_R, col_index, input_ready,
           core_rst, disp_valid, disp_out, disp_col
  );

  modport slave (
    output pix_valid, pix_sof, pix_L, pix_R, done, output_disp,
`ifdef DISP_FEEDER_TIMEOUT_EN
    input  timeout_err,
`endif
    input  pix_ready, input_array_L, input_array_R, col_index, input_ready,
           core_rst, disp_valid, disp_out, disp_col
  );

endinterface

// File: rtl/disp_row_shifter.sv
// One image's line buffer: a staging row written pixel by pixel plus a
// WIN-row shift array; row 0 is the oldest row, row WIN-1 the newest.
module disp_row_shifter
  import disp_pkg::*;
#(
  parameter int unsigned WIN       = WIN_DEF,
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned IMG_W     = IMG_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [$clog2(IMG_W)-1:0]         wr_idx,
  input  logic [DATA_SIZE-1:0]             wr_data,
  input  logic                             shift,
  output logic [DATA_SIZE*IMG_W*WIN-1:0]   rows
);
  localparam int unsigned ROW_W = DATA_SIZE * IMG_W;
  localparam int unsigned ARR_W = ROW_W * WIN;

  logic [ROW_W-1:0] staging;
  logic [ROW_W-1:0] staging_next;

  // The row-completing pixel must land in the row shifted in the same cycle.
  always_comb begin
    staging_next = staging;
    if (wr_en) begin
      staging_next[pix_offset(0, 32'(wr_idx), IMG_W, DATA_SIZE) +: DATA_SIZE] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      staging <= '0;
      rows    <= '0;
    end else begin
      staging <= staging_next;
      if (shift) begin
        rows <= {staging_next, rows[ARR_W-1:ROW_W]};
      end
    end
  end

endmodule

// File: rtl/disp_window_feeder.sv
// Fills WIN-row line buffers from a pixel stream and sweeps compute_max_disp
// over every window column. Optional watchdog: DISP_FEEDER_TIMEOUT_EN.
module disp_window_feeder
  import disp_pkg::*;
#(
  parameter int unsigned WIN       = WIN_DEF,
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned IMG_W     = IMG_W_DEF,
  parameter int unsigned MAX_DISP  = MAX_DISP_DEF
`ifdef DISP_FEEDER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
  input logic                  clk,
  input logic                  rst,
  disp_window_feeder_if.master bus
);
  localparam int unsigned DISP_W = $clog2(MAX_DISP);
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned CNT_W  = $clog2(WIN + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - WIN);
  localparam logic [COL_W-1:0] PIX_LAST = COL_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_FULL = CNT_W'(WIN);

  state_t            state, state_next;
  logic [COL_W-1:0]  pix_cnt, eff_pix, col_index;
  logic [CNT_W-1:0]  row_cnt, eff_row, row_inc;
  logic              xfer, row_done, finish;
  logic [DISP_W-1:0] result;

  assign bus.col_index = col_index;

`ifdef DISP_FEEDER_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt;
  logic            expired;
  assign expired = (state == WAIT) && !bus.done && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign finish  = bus.done || expired;
  assign result  = bus.done ? bus.output_disp : '0;
`else
  assign finish  = bus.done;
  assign result  = bus.output_disp;
`endif

  // pix_sof restarts both counters before the write of its own pixel.
  always_comb begin
    xfer     = bus.pix_valid && bus.pix_ready;
    eff_pix  = bus.pix_sof ? '0 : pix_cnt;
    eff_row  = bus.pix_sof ? '0 : row_cnt;
    row_done = xfer && (eff_pix == PIX_LAST);
    row_inc  = (eff_row == ROW_FULL) ? ROW_FULL : eff_row + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (row_done && (row_inc == ROW_FULL)) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (finish) state_next = CLR;
      CLR:     state_next = (col_index == COL_LAST) ? FILL : ISSUE;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    bus.pix_ready   = (state == FILL) && !rst;
    bus.input_ready = (state == ISSUE) && !rst;
    bus.core_rst    = (state == CLR) || rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt        <= '0;
      row_cnt        <= '0;
      col_index      <= '0;
      bus.disp_valid <= 1'b0;
      bus.disp_out   <= '0;
      bus.disp_col   <= '0;
`ifdef DISP_FEEDER_TIMEOUT_EN
      to_cnt          <= '0;
      bus.timeout_err <= 1'b0;
`endif
    end else begin
      bus.disp_valid <= (state == WAIT) && finish;
      if ((state == WAIT) && finish) begin
        bus.disp_out <= result;
        bus.disp_col <= col_index;
      end
      if (xfer) begin
        pix_cnt <= row_done ? '0 : eff_pix + 1'b1;
        row_cnt <= row_done ? row_inc : eff_row;
      end
      if (state == CLR) begin
        col_index <= (col_index == COL_LAST) ? '0 : col_index + 1'b1;
      end
`ifdef DISP_FEEDER_TIMEOUT_EN
      to_cnt <= (state == WAIT) ? to_cnt + 1'b1 : '0;
      if (expired) bus.timeout_err <= 1'b1;
`endif
    end
  end

  disp_row_shifter #(.WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W)) u_shift_l (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (xfer),
    .wr_idx  (eff_pix),
    .wr_data (bus.pix_L),
    .shift   (row_done),
    .rows    (bus.input_array_L)
  );

  disp_row_shifter #(.WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W)) u_shift_r (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (xfer),
    .wr_idx  (eff_pix),
    .wr_data (bus.pix_R),
    .shift   (row_done),
    .rows    (bus.input_array_R)
  );

endmodule

// File: tb/tb_disp_window_feeder.sv
// Bench for disp_window_feeder with WIN=3, IMG_W=8, MAX_DISP=4 and a
// behavioural core answering col_index%4 five cycles after each start.
module tb_disp_window_feeder;
  localparam int unsigned WIN = 3, IMG_W = 8, DS = 8, MAX_DISP = 4, TO_CYC = 16;
  localparam int unsigned NWIN  = IMG_W - WIN + 1;
  localparam int unsigned ARR_W = DS * IMG_W * WIN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  disp_window_feeder_if #(.WIN(WIN), .DATA_SIZE(DS), .IMG_W(IMG_W), .MAX_DISP(MAX_DISP)) bus();

  disp_window_feeder #(
    .WIN(WIN), .DATA_SIZE(DS), .IMG_W(IMG_W), .MAX_DISP(MAX_DISP)
`ifdef DISP_FEEDER_TIMEOUT_EN
    , .TIMEOUT_CYC(TO_CYC)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int unsigned col; int unsigned disp; } exp_t;
  typedef struct { bit sof; int unsigned npix; bit stall; int unsigned exp_strobes; } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int checks = 0, errors = 0;
  int dv_count = 0, ir_count = 0, cyc = 0, ir_cyc = 0;
  bit prev_ir = 1'b0, core_hang = 1'b0;

  logic [DS-1:0] m_stage_l [IMG_W], m_stage_r [IMG_W];
  logic [DS-1:0] m_rows_l [WIN][IMG_W], m_rows_r [WIN][IMG_W];
  int unsigned m_pix, m_row;

  task automatic check(input string name, input logic [ARR_W-1:0] got, input logic [ARR_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++) begin
        m_rows_l[r][c] = '0;
        m_rows_r[r][c] = '0;
      end
    for (int c = 0; c < IMG_W; c++) begin
      m_stage_l[c] = '0;
      m_stage_r[c] = '0;
    end
    m_pix = 0;
    m_row = 0;
  endtask

  task automatic model_px(input bit sof, input logic [DS-1:0] l, input logic [DS-1:0] r);
    if (sof) begin
      m_pix = 0;
      m_row = 0;
    end
    m_stage_l[m_pix] = l;
    m_stage_r[m_pix] = r;
    if (m_pix == IMG_W - 1) begin
      for (int k = 0; k < WIN - 1; k++) begin
        m_rows_l[k] = m_rows_l[k+1];
        m_rows_r[k] = m_rows_r[k+1];
      end
      m_rows_l[WIN-1] = m_stage_l;
      m_rows_r[WIN-1] = m_stage_r;
      m_pix = 0;
      if (m_row < WIN) m_row++;
      if (m_row == WIN)
        for (int c = 0; c < NWIN; c++)
          sb.push_back('{col: c, disp: core_hang ? 0 : c % 4});
    end else begin
      m_pix++;
    end
  endtask

  function automatic logic [ARR_W-1:0] model_arr(input bit right);
    logic [ARR_W-1:0] a = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++)
        a[(r*IMG_W+c)*DS +: DS] = right ? m_rows_r[r][c] : m_rows_l[r][c];
    return a;
  endfunction

  // Called at a negedge; returns at the negedge after the transfer.
  task automatic send_px(input bit sof, input bit stall);
    int guard = 0;
    logic [DS-1:0] l, r;
    l = DS'($urandom);
    r = DS'($urandom);
    if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    bus.pix_L     = l;
    bus.pix_R     = r;
    while (!bus.pix_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      errors++;
      $display("FAIL pix_ready_timeout: got 0 expected 1");
    end else begin
      @(negedge clk);
      model_px(sof, l, r);
    end
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !bus.pix_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", ARR_W'(n < 400), 1);
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    sb.delete();
    @(negedge clk);
  endtask

  // Behavioural compute_max_disp core.
  int unsigned core_cnt = 0;
  bit core_busy = 1'b0;
  logic [$clog2(IMG_W)-1:0] lat_col = '0;
  always @(negedge clk) begin
    bus.done = 1'b0;
    if (rst) bus.output_disp = '0;
    if (rst || bus.core_rst) begin
      core_busy = 1'b0;
    end else if (core_busy) begin
      core_cnt--;
      if (core_cnt == 0) begin
        bus.done = 1'b1;
        bus.output_disp = 2'(lat_col % 4);
        core_busy = 1'b0;
      end
    end else if (bus.input_ready && !core_hang) begin
      core_busy = 1'b1;
      core_cnt  = 5;
      lat_col   = bus.col_index;
    end
  end

  // Scoreboard side: pop and compare on every result strobe.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (bus.disp_valid) begin
      dv_count++;
      check("disp_latency", ARR_W'(cyc - ir_cyc), core_hang ? TO_CYC + 1 : 6);
      check("pix_ready_in_sweep", ARR_W'(bus.pix_ready), 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_disp_valid: got col %0d disp %0d expected no strobe",
                 bus.disp_col, bus.disp_out);
      end else begin
        e = sb.pop_front();
        check("disp_col", ARR_W'(bus.disp_col), ARR_W'(e.col));
        check("disp_out", ARR_W'(bus.disp_out), ARR_W'(e.disp));
      end
    end
    if (bus.input_ready) begin
      ir_count++;
      ir_cyc = cyc;
      check("input_ready_single", ARR_W'(prev_ir), 0);
      check("pix_ready_in_sweep", ARR_W'(bus.pix_ready), 0);
    end
    prev_ir = bus.input_ready;
  end

  initial begin
    bit found;
    vecs[0] = '{sof: 1'b1, npix: 24, stall: 1'b0, exp_strobes: 6};  // three rows fill buffer
    vecs[1] = '{sof: 1'b0, npix: 8,  stall: 1'b0, exp_strobes: 6};  // fourth row slides in
    vecs[2] = '{sof: 1'b1, npix: 12, stall: 1'b0, exp_strobes: 0};  // sof, 1.5 rows
    vecs[3] = '{sof: 1'b0, npix: 12, stall: 1'b0, exp_strobes: 6};  // completes 3 rows
    vecs[4] = '{sof: 1'b1, npix: 24, stall: 1'b1, exp_strobes: 6};  // stalled stream

    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_L     = '0;
    bus.pix_R     = '0;
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pix_ready",   ARR_W'(bus.pix_ready), 0);
    check("rst_input_ready", ARR_W'(bus.input_ready), 0);
    check("rst_core_rst",    ARR_W'(bus.core_rst), 1);
    check("rst_disp_valid",  ARR_W'(bus.disp_valid), 0);
    check("rst_disp_out",    ARR_W'(bus.disp_out), 0);
    check("rst_disp_col",    ARR_W'(bus.disp_col), 0);
    check("rst_col_index",   ARR_W'(bus.col_index), 0);
    check("rst_array_l",     bus.input_array_L, '0);
    check("rst_array_r",     bus.input_array_R, '0);
    rst = 1'b0;
    @(negedge clk);
    check("fill_pix_ready", ARR_W'(bus.pix_ready), 1);
    check("fill_core_rst",  ARR_W'(bus.core_rst), 0);

    for (int v = 0; v < 5; v++) begin
      dv_count = 0;
      ir_count = 0;
      for (int i = 0; i < int'(vecs[v].npix); i++) send_px(vecs[v].sof && i == 0, vecs[v].stall);
      wait_idle();
      check($sformatf("vec%0d_strobes", v), ARR_W'(dv_count), ARR_W'(vecs[v].exp_strobes));
      check($sformatf("vec%0d_starts", v),  ARR_W'(ir_count), ARR_W'(vecs[v].exp_strobes));
      check($sformatf("vec%0d_array_l", v), bus.input_array_L, model_arr(1'b0));
      check($sformatf("vec%0d_array_r", v), bus.input_array_R, model_arr(1'b1));
    end

    // Reset while waiting on column 2.
    do_reset();
    for (int i = 0; i < 24; i++) send_px(i == 0, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (bus.col_index == 2 && !bus.input_ready && !bus.pix_ready && !bus.core_rst && !bus.disp_valid)
        found = 1'b1;
      else
        @(negedge clk);
    end
    check("wait_col2_reached", ARR_W'(found), 1);
    sb.delete();
    rst = 1'b1;
    #1;
    check("midrst_core_rst_now", ARR_W'(bus.core_rst), 1);
    check("midrst_input_ready",  ARR_W'(bus.input_ready), 0);
    @(negedge clk);
    check("midrst_core_rst",   ARR_W'(bus.core_rst), 1);
    check("midrst_pix_ready",  ARR_W'(bus.pix_ready), 0);
    check("midrst_disp_valid", ARR_W'(bus.disp_valid), 0);
    check("midrst_col_index",  ARR_W'(bus.col_index), 0);
    check("midrst_disp_out",   ARR_W'(bus.disp_out), 0);
    check("midrst_disp_col",   ARR_W'(bus.disp_col), 0);
    check("midrst_array_l",    bus.input_array_L, '0);
    check("midrst_array_r",    bus.input_array_R, '0);
    rst = 1'b0;
    model_reset();
    dv_count = 0;
    @(negedge clk);
    check("midrst_back_to_fill", ARR_W'(bus.pix_ready), 1);
    repeat (20) @(negedge clk);
    check("midrst_no_strobe", ARR_W'(dv_count), 0);

`ifdef DISP_FEEDER_TIMEOUT_EN
    do_reset();
    check("timeout_err_clear", ARR_W'(bus.timeout_err), 0);
    core_hang = 1'b1;
    dv_count = 0;
    for (int i = 0; i < 24; i++) send_px(i == 0, 1'b0);
    wait_idle();
    check("timeout_strobes", ARR_W'(dv_count), 6);
    check("timeout_err_set", ARR_W'(bus.timeout_err), 1);
    repeat (5) @(negedge clk);
    check("timeout_err_held", ARR_W'(bus.timeout_err), 1);
    core_hang = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_window_feeder.md
Name: disp_window_feeder

Overview:
- Initiator side of the compute_max_disp interface.
- Accepts a raster pixel stream of paired left/right pixels and holds the newest WIN rows of each image in shift-register line buffers.
- Once WIN rows are held, sweeps col_index over every valid window position. For each position it pulses start, waits for done, captures the disparity and emits it on a valid-strobed result port.
- Sits between the camera/DMA pixel source and compute_max_disp.

Parameters:
- WIN, 15, window height/width in pixels.
- DATA_SIZE, 8, bits per pixel.
- IMG_W, 64, image width in pixels.
- MAX_DISP, 64, disparity range; DISP_BITS = $clog2(MAX_DISP).
- TIMEOUT_CYC, 4096, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_valid  in  1  pixel pair present
- pix_ready  out  1  feeder accepts pixel pair
- pix_sof  in  1  first pixel of frame; qualified by pix_valid
- pix_L  in  DATA_SIZE  left pixel
- pix_R  in  DATA_SIZE  right pixel
- input_array_L  out  DATA_SIZE*IMG_W*WIN  left window rows to core
- input_array_R  out  DATA_SIZE*IMG_W*WIN  right window rows to core
- col_index  out  $clog2(IMG_W)  window column to core
- input_ready  out  1  one-cycle start pulse to core
- core_rst  out  1  one-cycle core reset pulse between windows
- done  in  1  core finished; output_disp valid
- output_disp  in  DISP_BITS  core result
- disp_valid  out  1  one-cycle result strobe
- disp_out  out  DISP_BITS  captured disparity
- disp_col  out  $clog2(IMG_W)  column of disp_out

Behaviour:
- Reset values: all outputs 0, line buffers 0, row_cnt=0, pix_cnt=0, state FILL.
- Array layout: pixel (row r, col c) sits at bit offset (r*IMG_W+c)*DATA_SIZE. Row 0 is the oldest row, row WIN-1 the newest.
- FILL state:
  - pix_ready=1. A pixel transfers on pix_valid&&pix_ready.
  - Each transfer writes staging_row[pix_cnt] and increments pix_cnt.
  - pix_sof on a transfer forces pix_cnt=0 and row_cnt=0 before the write; a partial row is discarded.
  - When pix_cnt reaches IMG_W-1 on a transfer:
    - both arrays shift: array <= {staging_row, array[top WIN-1 rows]}; the oldest row drops out.
    - pix_cnt wraps to 0 and row_cnt saturates at WIN.
    - if row_cnt (post-increment) == WIN, go to ISSUE with col_index=0; otherwise stay in FILL.
- ISSUE state:
  - pix_ready=0; input_ready=1 for exactly one cycle; go to WAIT.
- WAIT state:
  - input_ready=0; col_index and both arrays held stable.
  - On done=1: capture output_disp into disp_out, drive disp_col=col_index, pulse disp_valid for one cycle, go to CLR.
- CLR state:
  - core_rst=1 for one cycle.
  - If col_index == IMG_W-WIN: col_index<=0, go to FILL (next row slides in).
  - Otherwise: col_index+1, go to ISSUE.
- Per-window overhead: 3 cycles plus core latency. IMG_W-WIN+1 windows are issued per completed row once the buffer is full.
- done outside WAIT is ignored.
- pix_sof arrives only while in FILL, because pix_ready=0 elsewhere.
- rst mid-sweep: returns to FILL, clears both arrays and counters, and drives core_rst=1 in that cycle.
- Width rules:
  - col_index counts 0..IMG_W-WIN and never wraps past that bound.
  - row_cnt has width $clog2(WIN+1).

Optional Feature:
- Macro: DISP_FEEDER_TIMEOUT_EN.
- With the macro: a counter runs in WAIT. If it reaches TIMEOUT_CYC without done, the feeder emits disp_valid with disp_out=0 and asserts an extra output port timeout_err (1 bit, sticky until rst), then proceeds to CLR as normal.
- Without the macro: WAIT blocks indefinitely; no counter and no timeout_err port.

Decomposition:
- Package disp_pkg holds:
  - localparams DISP_BITS, COL_BITS=$clog2(IMG_W), ROW_BITS=$clog2(WIN+1)
  - the state enum FILL/ISSUE/WAIT/CLR
  - a function giving the bit offset of (r,c)
- Sub-module disp_row_shifter, instantiated once per image: staging row plus WIN-row shift array with write and shift strobes.
- The FSM stays in disp_window_feeder.

Test Plan:
- Bench parameters unless stated: WIN=3, IMG_W=8, MAX_DISP=4, with a behavioural core that returns col_index%4 after 5 cycles.
1. Stream 3 rows (pix_sof on the first pixel) -> exactly 6 disp_valid strobes, disp_col 0..5, disp_out 0,1,2,3,0,1; pix_ready=0 during the sweep.
2. Stream a 4th row -> array row 0 equals old row 1 and row 2 holds the new row; 6 more strobes.
3. pix_sof after 1.5 rows -> row_cnt restarts; no input_ready pulse until 3 full rows after the sof.
4. Assert rst during WAIT on col 2 -> next cycle all outputs 0, state FILL, core_rst=1; no disp_valid.
5. Stall pix_valid randomly at 50% -> same disp sequence as scenario 1; input_ready never high two consecutive cycles.
6. Under DISP_FEEDER_TIMEOUT_EN with TIMEOUT_CYC=16 and a core that never raises done -> disp_valid with disp_out=0 after 16 WAIT cycles, timeout_err=1 and held.
